// File: rtl/aes256_dec_fsm.sv
// aes256_dec_fsm: iterative AES-256 inverse cipher, one round per clock
//   clk, resetn         : clock, synchronous active-low reset
//   ctrl_dataIn, inpAES : ciphertext strobe and block (bits [127:120] = byte 0)
//   rk_wr, rk_addr,
//   rk_data             : round-key file write port (index 0..14, IDLE only)
//   outAES, ctrl_dataOut: plaintext and its one-cycle valid pulse
//   ready               : high when a new block can be accepted
//   ovf                 : sticky overlap flag, present only with AES256_DEC_OVF_EN
module aes256_dec_fsm (
    input  logic         clk,
    input  logic         resetn,
    input  logic         ctrl_dataIn,
    input  logic [127:0] inpAES,
    input  logic         rk_wr,
    input  logic [3:0]   rk_addr,
    input  logic [127:0] rk_data,
    output logic [127:0] outAES,
    output logic         ctrl_dataOut,
    output logic         ready
`ifdef AES256_DEC_OVF_EN
    ,
    output logic         ovf
`endif
);
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t       fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;
    logic [127:0] out_q, out_d;
    logic [127:0] rk_q [0:14];
    logic [127:0] core;

    function automatic logic [7:0] isb(input logic [7:0] x);
        return INV_SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    // Multiply by a constant whose bits select b, 2b, 4b, 8b in GF(2^8)
    function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
        x4 = {x2[6:0], 1'b0} ^ (x2[7] ? 8'h1b : 8'h00);
        x8 = {x4[6:0], 1'b0} ^ (x4[7] ? 8'h1b : 8'h00);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? b : 8'h00);
    endfunction

    // Byte 4c+r of the state sits in column c, row r; row r rotates right by r
    function automatic logic [127:0] isr_isb(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (4 * c + r) -: 8] = isb(s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9);
            o[119 - 32 * c -: 8] = gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd);
            o[111 - 32 * c -: 8] = gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb);
            o[103 - 32 * c -: 8] = gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he);
        end
        return o;
    endfunction

    assign core         = isr_isb(st_q);
    assign outAES       = out_q;
    assign ctrl_dataOut = fsm_q == DONE;
    assign ready        = fsm_q != ROUND;

    always_comb begin
        fsm_d = fsm_q;
        rnd_d = rnd_q;
        st_d  = st_q;
        out_d = out_q;
        if (fsm_q == ROUND) begin
            if (rnd_q == 4'd0) begin
                out_d = core ^ rk_q[0];
                fsm_d = DONE;
            end else begin
                st_d  = inv_mix(core ^ rk_q[rnd_q]);
                rnd_d = rnd_q - 4'd1;
            end
        end else if (ctrl_dataIn) begin
            st_d  = inpAES ^ rk_q[14];
            rnd_d = 4'd13;
            fsm_d = ROUND;
        end else begin
            fsm_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fsm_q <= IDLE;
            rnd_q <= '0;
            st_q  <= '0;
            out_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            rnd_q <= rnd_d;
            st_q  <= st_d;
            out_q <= out_d;
        end
    end

    // Key file survives reset so blocks can be re-issued without a reload
    always_ff @(posedge clk)
        if (rk_wr && fsm_q == IDLE && rk_addr != 4'd15)
            rk_q[rk_addr] <= rk_data;

`ifdef AES256_DEC_OVF_EN
    logic ovf_q, ovf_d;
    assign ovf   = ovf_q;
    assign ovf_d = ovf_q | (fsm_q == ROUND && ctrl_dataIn);
    always_ff @(posedge clk)
        ovf_q <= resetn ? ovf_d : 1'b0;
`endif
endmodule

// File: tb/tb_aes256_dec_fsm.sv
// tb_aes256_dec_fsm: scoreboard bench for aes256_dec_fsm against a byte-level AES model
module tb_aes256_dec_fsm;
    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 0, resetn = 0, ctrl_dataIn = 0, rk_wr = 0;
    logic [127:0] inpAES = '0, rk_data = '0;
    logic [3:0]   rk_addr = '0;
    logic [127:0] outAES;
    logic         ctrl_dataOut, ready;
`ifdef AES256_DEC_OVF_EN
    logic         ovf;
`endif

    int n_chk = 0, n_fail = 0;

    logic [7:0]   sb [256];
    logic [7:0]   isb [256];
    logic [127:0] mrk [15];
    logic [127:0] exp_rk [15];
    logic [127:0] sb_q [$];
    logic [127:0] pending = '0, out_m = '0;
    int           busy = 0;
    bit           done_m = 0, live = 0, ovf_m = 0;

    always #5 clk = ~clk;

    aes256_dec_fsm dut (
        .clk(clk), .resetn(resetn), .ctrl_dataIn(ctrl_dataIn), .inpAES(inpAES),
        .rk_wr(rk_wr), .rk_addr(rk_addr), .rk_data(rk_data),
        .outAES(outAES), .ctrl_dataOut(ctrl_dataOut), .ready(ready)
`ifdef AES256_DEC_OVF_EN
        , .ovf(ovf)
`endif
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-boxes derived from the field inverse and the affine map
    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x] = b;
            isb[b] = 8'(x);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) begin
            if (i < 8) w[i] = k[255 - 32 * i -: 32];
            else begin
                t = w[i - 1];
                if (i % 8 == 0) begin
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (i % 8 == 4) t = subw(t);
                w[i] = w[i - 8] ^ t;
            end
        end
        for (int j = 0; j < 15; j++) exp_rk[j] = {w[4 * j], w[4 * j + 1], w[4 * j + 2], w[4 * j + 3]};
    endtask

    function automatic logic [127:0] dec(input logic [127:0] ct);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] m [4];
        logic [127:0] o;
        m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int k = 0; k < 16; k++) s[k] = ct[127 - 8 * k -: 8] ^ mrk[14][127 - 8 * k -: 8];
        for (int r = 13; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[4 * c + w] = isb[s[4 * ((c - w + 4) % 4) + w]] ^ mrk[r][127 - 8 * (4 * c + w) -: 8];
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 4; i++) begin
                    s[4 * c + i] = 0;
                    if (r == 0) s[4 * c + i] = t[4 * c + i];
                    else for (int j = 0; j < 4; j++) s[4 * c + i] ^= gmul(t[4 * c + j], m[(j - i + 4) % 4]);
                end
        end
        for (int k = 0; k < 16; k++) o[127 - 8 * k -: 8] = s[k];
        return o;
    endfunction

    // Transaction-level model: a block occupies the engine for 14 edges after acceptance
    always @(posedge clk) begin
        bit idle_pre, nd;
        idle_pre = busy == 0 && !done_m;
        nd = 0;
        if (!resetn) begin
            busy = 0; out_m = '0; ovf_m = 0; live = 1;
            sb_q.delete();
        end else begin
            if (busy > 0) begin
                if (ctrl_dataIn) ovf_m = 1;
                busy--;
                if (busy == 0) begin nd = 1; out_m = pending; end
            end else if (ctrl_dataIn) begin
                pending = dec(inpAES);
                sb_q.push_back(pending);
                busy = 14;
            end
            if (rk_wr && idle_pre && rk_addr != 4'd15) mrk[rk_addr] = rk_data;
        end
        done_m = nd;
    end

    always @(negedge clk) if (live) begin
        chk("ready", 128'(ready), 128'(busy == 0));
        chk("dout_pulse", 128'(ctrl_dataOut), 128'(done_m));
        chk("out_hold", outAES, out_m);
`ifdef AES256_DEC_OVF_EN
        chk("ovf", 128'(ovf), 128'(ovf_m));
`endif
        if (ctrl_dataOut) begin
            if (sb_q.size() == 0) chk("sb_unexpected", 128'(ctrl_dataOut), 128'd0);
            else chk("sb_out", outAES, sb_q.pop_front());
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic load_keys();
        for (int i = 0; i < 15; i++) begin
            rk_wr = 1; rk_addr = 4'(i); rk_data = exp_rk[i];
            tick();
        end
        rk_wr = 0;
    endtask

    task automatic issue(input logic [127:0] ct);
        ctrl_dataIn = 1; inpAES = ct;
        tick();
        ctrl_dataIn = 0;
    endtask

    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int pulses, lows;
        build_sbox();
        tick(3);
        resetn = 1;
        tick();
        expand(FIPS_KEY);
        load_keys();
        issue(FIPS_CT);
        tick(14);
        chk("fips_pulse", 128'(ctrl_dataOut), 128'd1);
        chk("fips_pt", outAES, FIPS_PT);
        tick();
        chk("fips_pulse_end", 128'(ctrl_dataOut), 128'd0);
        chk("fips_hold", outAES, FIPS_PT);
        tick(2);

        pulses = 0; lows = 0;
        ctrl_dataIn = 1; inpAES = FIPS_CT;
        repeat (45) begin
            tick();
            pulses += int'(ctrl_dataOut);
            lows += int'(!ready);
            if (ctrl_dataOut) chk("b2b_pt", outAES, FIPS_PT);
        end
        ctrl_dataIn = 0;
        chk("b2b_pulses", 128'(pulses), 128'd3);
        chk("b2b_ready_low", 128'(lows), 128'd42);
        tick(3);

        issue(FIPS_CT);
        tick(2);
        ctrl_dataIn = 1; inpAES = r128(); tick(); ctrl_dataIn = 0;
        tick(3);
        ctrl_dataIn = 1; inpAES = r128(); tick(); ctrl_dataIn = 0;
        tick(7);
        chk("ovl_pulse", 128'(ctrl_dataOut), 128'd1);
        chk("ovl_pt", outAES, FIPS_PT);
`ifdef AES256_DEC_OVF_EN
        chk("ovl_ovf", 128'(ovf), 128'd1);
`endif
        tick(3);

        rk_wr = 1; rk_addr = 4'd15; rk_data = r128(); tick(); rk_wr = 0;
        issue(FIPS_CT);
        rk_wr = 1;
        repeat (13) begin rk_addr = 4'($urandom_range(0, 14)); rk_data = r128(); tick(); end
        rk_wr = 0;
        tick();
        chk("rkdrop_pt", outAES, FIPS_PT);
        tick(2);
        issue(FIPS_CT);
        tick(14);
        chk("rkdrop_pt2", outAES, FIPS_PT);
        tick(2);

        issue(FIPS_CT);
        tick(5);
        resetn = 0; tick(); resetn = 1;
        chk("rst_ready", 128'(ready), 128'd1);
        chk("rst_out", outAES, 128'd0);
        chk("rst_pulse", 128'(ctrl_dataOut), 128'd0);
        pulses = 0;
        repeat (16) begin tick(); pulses += int'(ctrl_dataOut); end
        chk("rst_no_pulse", 128'(pulses), 128'd0);
        issue(FIPS_CT);
        tick(14);
        chk("rst_reissue_pt", outAES, FIPS_PT);
        tick(2);

        for (int i = 0; i < 15; i++) exp_rk[i] = '0;
        load_keys();
        issue('0);
        tick(16);

        for (int k = 0; k < 2; k++) begin
            expand({r128(), r128()});
            load_keys();
            repeat (150) begin
                ctrl_dataIn = $urandom_range(0, 2) == 0;
                inpAES = r128();
                tick();
            end
            ctrl_dataIn = 0;
            tick(16);
        end

        chk("sb_drain", 128'(sb_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
